// File: rtl/sa_wb_cache.sv
// N-way set-associative write-back/write-allocate data cache with true-LRU, byte-enable stores and whole-cache flush.
// Hits complete in one cycle (rd_data registered); misses/flush hold miss=1 until line traffic with memory completes.
module sa_wb_cache #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 2,
    parameter int TAG_ADDR_LEN  = 6,
    parameter int WAY_CNT       = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [31:0]                             addr,
    input  logic                                    rd_req,
    input  logic [3:0]                              wr_req,
    input  logic [31:0]                             wr_data,
    output logic [31:0]                             rd_data,
    output logic                                    miss,
    input  logic                                    flush_req,
    output logic                                    flush_done,
    output logic                                    mem_rd_req,
    output logic                                    mem_wr_req,
    output logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0]    mem_addr,
    output logic [32*(1<<LINE_ADDR_LEN)-1:0]        mem_wr_line,
    input  logic [32*(1<<LINE_ADDR_LEN)-1:0]        mem_rd_line,
    input  logic                                    mem_gnt
);
    localparam int SET_SIZE     = 1 << SET_ADDR_LEN;
    localparam int WAY_IDX      = $clog2(WAY_CNT);
    localparam int MEM_ADDR_LEN = TAG_ADDR_LEN + SET_ADDR_LEN;
    localparam int LINE_W       = 32 * (1 << LINE_ADDR_LEN);
    localparam int IDX_W        = SET_ADDR_LEN + WAY_IDX;

    typedef enum logic [2:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK, FLUSH_SCAN, FLUSH_WB} state_t;
    typedef logic [WAY_CNT-1:0][WAY_IDX-1:0] ages_t;

    state_t                  state_q, state_d;
    logic [LINE_W-1:0]       data_q [SET_SIZE][WAY_CNT];
    logic [LINE_W-1:0]       data_d [SET_SIZE][WAY_CNT];
    logic [TAG_ADDR_LEN-1:0] tag_q  [SET_SIZE][WAY_CNT];
    logic [TAG_ADDR_LEN-1:0] tag_d  [SET_SIZE][WAY_CNT];
    logic [WAY_CNT-1:0]      valid_q [SET_SIZE], valid_d [SET_SIZE];
    logic [WAY_CNT-1:0]      dirty_q [SET_SIZE], dirty_d [SET_SIZE];
    ages_t                   age_q [SET_SIZE], age_d [SET_SIZE];
    logic [31:0]             rd_data_q, rd_data_d;
    logic                    flush_done_q, flush_done_d;
    logic                    mem_rd_req_q, mem_rd_req_d, mem_wr_req_q, mem_wr_req_d;
    logic [MEM_ADDR_LEN-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]       mem_wr_line_q, mem_wr_line_d, fill_q, fill_d;
    logic [TAG_ADDR_LEN-1:0] rtag_q, rtag_d;
    logic [SET_ADDR_LEN-1:0] rset_q, rset_d;
    logic [WAY_IDX-1:0]      vway_q, vway_d;
    logic [IDX_W-1:0]        fidx_q, fidx_d;

    logic [TAG_ADDR_LEN-1:0]  req_tag;
    logic [SET_ADDR_LEN-1:0]  req_set, fset;
    logic [LINE_ADDR_LEN-1:0] req_word;
    logic [WAY_IDX-1:0]       hit_way, vic_way, fway;
    logic                     req, hit, addr_unused;
    logic [LINE_W-1:0]        line_tmp;

    assign req_word    = addr[2 +: LINE_ADDR_LEN];
    assign req_set     = addr[2+LINE_ADDR_LEN +: SET_ADDR_LEN];
    assign req_tag     = addr[2+LINE_ADDR_LEN+SET_ADDR_LEN +: TAG_ADDR_LEN];
    assign addr_unused = ^{addr[31:2+LINE_ADDR_LEN+MEM_ADDR_LEN], addr[1:0]};
    assign fset        = fidx_q[IDX_W-1:WAY_IDX];
    assign fway        = fidx_q[WAY_IDX-1:0];
    assign req         = rd_req | (|wr_req);
    assign miss        = req & ~(hit & (state_q == IDLE));

    assign rd_data     = rd_data_q;
    assign flush_done  = flush_done_q;
    assign mem_rd_req  = mem_rd_req_q;
    assign mem_wr_req  = mem_wr_req_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_line = mem_wr_line_q;

    // Touched way becomes youngest; only ways younger than it age, so ages stay a permutation.
    function automatic ages_t touch(input ages_t a, input logic [WAY_IDX-1:0] k);
        ages_t r;
        r = a;
        for (int w = 0; w < WAY_CNT; w++)
            if (a[w] < a[k]) r[w] = a[w] + WAY_IDX'(1);
        r[k] = '0;
        return r;
    endfunction

    always_comb begin
        hit = 1'b0; hit_way = '0; vic_way = '0;
        for (int w = 0; w < WAY_CNT; w++) begin
            if (valid_q[req_set][w] && tag_q[req_set][w] == req_tag) begin
                hit = 1'b1; hit_way = WAY_IDX'(w);
            end
            if (age_q[req_set][w] == WAY_IDX'(WAY_CNT - 1)) vic_way = WAY_IDX'(w);
        end
        for (int w = WAY_CNT - 1; w >= 0; w--)
            if (!valid_q[req_set][w]) vic_way = WAY_IDX'(w);
    end

    always_comb begin
        state_d = state_q; data_d = data_q; tag_d = tag_q; valid_d = valid_q; dirty_d = dirty_q;
        age_d = age_q; rd_data_d = rd_data_q; flush_done_d = 1'b0;
        mem_rd_req_d = mem_rd_req_q; mem_wr_req_d = mem_wr_req_q;
        mem_addr_d = mem_addr_q; mem_wr_line_d = mem_wr_line_q; fill_d = fill_q;
        rtag_d = rtag_q; rset_d = rset_q; vway_d = vway_q; fidx_d = fidx_q;
        line_tmp = '0;
        case (state_q)
            IDLE: begin
                if (req && hit) begin
                    age_d[req_set] = touch(age_q[req_set], hit_way);
                    if (rd_req) begin
                        rd_data_d = data_q[req_set][hit_way][32*req_word +: 32];
                    end else begin
                        line_tmp = data_q[req_set][hit_way];
                        for (int b = 0; b < 4; b++)
                            if (wr_req[b]) line_tmp[32*req_word + 8*b +: 8] = wr_data[8*b +: 8];
                        data_d[req_set][hit_way]  = line_tmp;
                        dirty_d[req_set][hit_way] = 1'b1;
                    end
                end
                if (flush_req) begin
                    state_d = FLUSH_SCAN; fidx_d = '0;
                end else if (req && !hit) begin
                    rtag_d = req_tag; rset_d = req_set; vway_d = vic_way;
                    if (valid_q[req_set][vic_way] && dirty_q[req_set][vic_way]) begin
                        state_d       = SWAP_OUT;
                        mem_wr_req_d  = 1'b1;
                        mem_addr_d    = {tag_q[req_set][vic_way], req_set};
                        mem_wr_line_d = data_q[req_set][vic_way];
                    end else begin
                        state_d      = SWAP_IN;
                        mem_rd_req_d = 1'b1;
                        mem_addr_d   = {req_tag, req_set};
                    end
                end
            end
            SWAP_OUT: if (mem_gnt) begin
                state_d = SWAP_IN; mem_wr_req_d = 1'b0; mem_rd_req_d = 1'b1; mem_addr_d = {rtag_q, rset_q};
            end
            SWAP_IN: if (mem_gnt) begin
                state_d = SWAP_IN_OK; mem_rd_req_d = 1'b0; mem_addr_d = '0; fill_d = mem_rd_line;
            end
            SWAP_IN_OK: begin
                data_d[rset_q][vway_q]  = fill_q;
                tag_d[rset_q][vway_q]   = rtag_q;
                valid_d[rset_q][vway_q] = 1'b1;
                dirty_d[rset_q][vway_q] = 1'b0;
                age_d[rset_q]           = touch(age_q[rset_q], vway_q);
                state_d                 = IDLE;
            end
            FLUSH_SCAN: begin
                if (valid_q[fset][fway] && dirty_q[fset][fway]) begin
                    state_d       = FLUSH_WB;
                    mem_wr_req_d  = 1'b1;
                    mem_addr_d    = {tag_q[fset][fway], fset};
                    mem_wr_line_d = data_q[fset][fway];
                end else begin
                    valid_d[fset][fway] = 1'b0;
                    dirty_d[fset][fway] = 1'b0;
                    if (&fidx_q) begin state_d = IDLE; flush_done_d = 1'b1; end
                    else fidx_d = fidx_q + IDX_W'(1);
                end
            end
            FLUSH_WB: if (mem_gnt) begin
                mem_wr_req_d = 1'b0; mem_addr_d = '0;
                valid_d[fset][fway] = 1'b0;
                dirty_d[fset][fway] = 1'b0;
                if (&fidx_q) begin state_d = IDLE; flush_done_d = 1'b1; end
                else begin state_d = FLUSH_SCAN; fidx_d = fidx_q + IDX_W'(1); end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        data_q <= data_d; tag_q <= tag_d; fill_q <= fill_d;
        rtag_q <= rtag_d; rset_q <= rset_d; vway_q <= vway_d; fidx_q <= fidx_d;
        if (rst) begin
            state_q <= IDLE; rd_data_q <= '0; flush_done_q <= 1'b0;
            mem_rd_req_q <= 1'b0; mem_wr_req_q <= 1'b0; mem_addr_q <= '0; mem_wr_line_q <= '0;
            for (int s = 0; s < SET_SIZE; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAY_CNT; w++) age_q[s][w] <= WAY_IDX'(w);
            end
        end else begin
            state_q <= state_d; rd_data_q <= rd_data_d; flush_done_q <= flush_done_d;
            mem_rd_req_q <= mem_rd_req_d; mem_wr_req_q <= mem_wr_req_d;
            mem_addr_q <= mem_addr_d; mem_wr_line_q <= mem_wr_line_d;
            valid_q <= valid_d; dirty_q <= dirty_d; age_q <= age_d;
        end
    end
endmodule
